// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
//   fetch_state_t : request sequencer states of instr_fetch_unit
//   NOP           : instruction word presented when nothing is buffered
//   word_tag()    : word-address tag (bits [31:2]) of a byte address
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [29:0] word_tag(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Prefetch FIFO: synchronous push/pop, single-cycle flush, occupancy count
// and first-word-fall-through head output.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write din at the tail (dropped when full unless popping too)
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   head       : current head entry (undefined contents when empty)
//   count      : number of stored entries, 0..DEPTH
//   empty/full : occupancy flags
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 62
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage between a single-cycle MIPS core and a
// variable-latency instruction memory. Sequential words are prefetched into
// a tagged FIFO; the head is presented as instr when its tag matches the
// core PC. A PC that differs from the expected next address (taken branch or
// jump) flushes the FIFO and restarts fetching at the new PC.
//   clk, reset   : clock, asynchronous active-low reset
//   pc, pc_en    : core PC (bits [1:0] ignored) and execute strobe
//   instr        : instruction for pc (NOP when FIFO empty)
//   instr_valid  : FIFO head tag matches pc[31:2]
//   imem_req/addr/gnt        : request handshake. imem_req stays high with a
//                  stable imem_addr until the cycle imem_req & imem_gnt,
//                  which is the acceptance cycle; imem_req is never withdrawn.
//   imem_rvalid/imem_rdata   : one read response per accepted request
//   state        : sequencer state, for observation
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc,
  input  logic         pc_en,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output fetch_state_t state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_addr, fetch_addr_d;
  logic [31:0]   imem_addr_d;
  logic          drain_pend, drain_pend_d;

  logic [61:0]   head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [29:0]   head_tag;
  logic [29:0]   expected_tag;
  logic [31:0]   pc_word;
  logic [31:0]   next_addr;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          room_after_push;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];
  assign pc_word        = {pc[31:2], 2'b00};
  assign next_addr      = fetch_addr + 32'd4;   // wraps FFFF_FFFC -> 0
  assign head_tag       = head[61:32];

  // When the FIFO is empty the next word the core should ask for is the one
  // being fetched (or about to be), so fetch_addr stands in for the head tag.
  assign expected_tag = empty ? word_tag(fetch_addr) : head_tag;
  assign redirect     = (word_tag(pc) != expected_tag);

  assign instr_valid = !empty && (head_tag == word_tag(pc));
  assign instr       = empty ? NOP : head[31:0];
  assign pop         = pc_en && instr_valid;
  // A response that coincides with a redirect belongs to the old stream.
  assign push        = (state_q == S_WAIT) && imem_rvalid && !redirect;
  // Count is below DEPTH whenever a response is pushed (a request is only
  // issued with room, and only pops happen meanwhile).
  assign room_after_push = pop || (count < CW'(DEPTH - 1));

  assign imem_req = (state_q == S_REQ);
  assign state    = state_q;

  instr_fifo #(.DEPTH(DEPTH), .W(62)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({word_tag(fetch_addr), imem_rdata}),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr;
    imem_addr_d  = imem_addr;
    drain_pend_d = drain_pend;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_addr_d = pc_word;
          imem_addr_d  = pc_word;
          state_d      = S_REQ;
        end else if (!full) begin
          imem_addr_d = fetch_addr;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // The outstanding request keeps its old address; remember that its
        // data must be thrown away once it returns.
        if (redirect) begin
          fetch_addr_d = pc_word;
          drain_pend_d = 1'b1;
        end
        if (imem_gnt) begin
          state_d      = (redirect || drain_pend) ? S_DRAIN : S_WAIT;
          drain_pend_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_addr_d = pc_word;
          if (imem_rvalid) begin
            // Stale response already consumed here: go straight to the new PC.
            imem_addr_d = pc_word;
            state_d     = S_REQ;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem_rvalid) begin
          fetch_addr_d = next_addr;
          if (room_after_push) begin
            imem_addr_d = next_addr;
            state_d     = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_addr_d = pc_word;
        if (imem_rvalid) begin
          imem_addr_d = redirect ? pc_word : fetch_addr;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_addr <= RESET_PC;
      imem_addr  <= RESET_PC;
      drain_pend <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_addr <= fetch_addr_d;
      imem_addr  <= imem_addr_d;
      drain_pend <= drain_pend_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A core driver issues PCs and
// pushes the expected instruction word into exp_q; a monitor pops and
// compares each time the DUT hands an instruction to the core. A memory
// model with programmable grant rate and latency serves requests.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic         clk;
  logic         reset;
  logic [31:0]  pc;
  logic         pc_en;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  fetch_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gnt_log[$];
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_en       (pc_en),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- memory model ----------------
  initial begin
    bit          acc;
    logic [31:0] acc_addr;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    pend = 0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc      = reset && imem_req && imem_gnt;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!reset) begin
        pend = 0;
      end else begin
        if (acc) begin
          gnt_log.push_back(acc_addr);
          pend      = 1;
          pend_addr = acc_addr;
          pend_cnt  = $urandom_range(lat_max, lat_min);
        end
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend = 0;
          end
        end
      end
      imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          prev_req;
    bit          prev_gnt;
    logic [31:0] prev_addr;
    prev_req = 0;
    prev_gnt = 0;
    prev_addr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (instr_valid && pc_en) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL instr_unexpected actual=%h required=no instruction", instr);
          end else begin
            check("instr", instr, exp_q.pop_front());
          end
        end
        if (imem_rvalid)
          check("rvalid_in_wait_or_drain",
                32'((dbg_state == S_WAIT) || (dbg_state == S_DRAIN)), 32'd1);
        if (prev_req && !prev_gnt && imem_req)
          check("imem_addr_stable", imem_addr, prev_addr);
      end
      prev_req  = reset && imem_req;
      prev_gnt  = imem_gnt;
      prev_addr = imem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    pc    = RESET_PC;
    pc_en = 1'b0;
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b1;
    gnt_log.delete();
  endtask

  // Present addr as the core PC until the instruction is consumed.
  task automatic consume(input logic [31:0] a, input int stall_pct);
    bit done;
    done = 0;
    pc = a;
    exp_q.push_back(mem_word(a));
    for (int n = 0; n < 400 && !done; n++) begin
      pc_en = ($urandom_range(99, 0) >= stall_pct);
      @(negedge clk);
      if (instr_valid && pc_en) done = 1;
      @(posedge clk);
      #1;
    end
    pc_en = 1'b0;
    if (!done) begin
      $display("FAIL consume_timeout pc=%h actual=no instr_valid required=instr_valid", a);
      total++;
      bad++;
      exp_q.delete();
    end
  endtask

  task automatic wait_grants(input int n, input int max_cycles);
    int k;
    k = 0;
    while (gnt_log.size() < n && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (gnt_log.size() < n) timeout_fail("wait_grants");
  endtask

  task automatic wait_state(input fetch_state_t s, input bit need_valid, input int max_cycles);
    int k;
    k = 0;
    while (!(dbg_state == s && (!need_valid || instr_valid)) && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!(dbg_state == s && (!need_valid || instr_valid))) timeout_fail("wait_state");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a;
    int idx;
    reset = 1'b0;
    pc = RESET_PC;
    pc_en = 1'b0;

    // 1: sequential fetch, latency 1
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    @(negedge clk);
    check("t1_no_req_before_edge", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) consume(32'(i * 4), 0);
    for (int i = 0; i < 8; i++) check("t1_req_order", log_at(i), 32'(i * 4));

    // 2: grants stalled, then FIFO fills with pc held
    do_reset();
    gnt_pct = 0;
    repeat (5) begin @(posedge clk); #1; end
    gnt_pct = 100;
    repeat (40) begin @(posedge clk); #1; end
    check("t2_fill_grants", 32'(gnt_log.size()), 32'd4);
    check("t2_state_idle", 32'(dbg_state), 32'(S_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_req_low_when_full", 32'(imem_req), 32'd0);
    end
    @(posedge clk);
    #1;

    // 3: jump with words buffered and an ungranted request outstanding
    gnt_pct = 0;
    @(posedge clk);
    #1;
    consume(32'h0, 0);
    consume(32'h4, 0);
    repeat (2) begin @(posedge clk); #1; end
    gnt_log.delete();
    pc = 32'h40;
    @(negedge clk);
    check("t3_valid_drop", 32'(instr_valid), 32'd0);
    check("t3_req_kept", 32'(imem_req), 32'd1);
    check("t3_addr_kept", imem_addr, 32'h10);
    @(posedge clk);
    #1;
    gnt_pct = 100;
    consume(32'h40, 0);
    check("t3_old_req_completes", log_at(0), 32'h10);
    check("t3_redirect_addr", log_at(1), 32'h40);
    consume(32'h44, 0);

    // 4: redirect while waiting on 0x10
    gnt_pct = 100; lat_min = 6; lat_max = 6;
    do_reset();
    wait_grants(4, 100);
    wait_state(S_IDLE, 0, 100);
    consume(32'h0, 0);
    pc = 32'h4;
    idx = 0;
    while (!(dbg_state == S_WAIT && log_at(gnt_log.size() - 1) == 32'h10) && idx < 100) begin
      @(posedge clk);
      #1;
      idx++;
    end
    check("t4_waiting_for_0x10", 32'(dbg_state == S_WAIT), 32'd1);
    gnt_log.delete();
    pc = 32'h100;
    @(posedge clk);
    #1;
    check("t4_drain", 32'(dbg_state), 32'(S_DRAIN));
    consume(32'h100, 0);
    check("t4_redirect_addr", log_at(0), 32'h100);

    // 5: reset asserted mid-wait
    do_reset();
    wait_state(S_WAIT, 1, 100);
    #1;
    reset = 1'b0;
    #1;
    check("t5_req_low", 32'(imem_req), 32'd0);
    check("t5_valid_low", 32'(instr_valid), 32'd0);
    check("t5_instr_nop", instr, NOP);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    gnt_log.delete();
    wait_grants(1, 20);
    check("t5_first_addr", log_at(0), RESET_PC);
    consume(32'h0, 0);
    consume(32'h4, 0);

    // 6: fetch address wrap-around
    lat_min = 2; lat_max = 2;
    gnt_log.delete();
    consume(32'hFFFF_FFF0, 0);
    consume(32'hFFFF_FFF4, 0);
    consume(32'hFFFF_FFF8, 0);
    consume(32'hFFFF_FFFC, 0);
    consume(32'h0000_0000, 0);
    consume(32'h0000_0004, 0);
    idx = -1;
    for (int i = 0; i < gnt_log.size(); i++)
      if (idx < 0 && gnt_log[i] == 32'hFFFF_FFFC) idx = i;
    check("t6_wrap_next_addr", log_at(idx + 1), 32'h0);

    // Random program flow: sequential runs, jumps, core stalls, memory jitter.
    lat_min = 1; lat_max = 4;
    a = 32'h0000_1000;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) gnt_pct = $urandom_range(100, 30);
      consume(a, 25);
      if ($urandom_range(99, 0) < 15) a = $urandom & 32'hFFFF_FFFC;
      else a = a + 32'd4;
    end

    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
